// File: rtl/denoise_pkg.sv
// denoise_pkg: shared types, widths and window geometry for the denoise frame controller
package denoise_pkg;
  typedef enum logic [1:0] {
    WAIT_VS     = 2'd0,
    WAIT_ACTIVE = 2'd1,
    RUN         = 2'd2
  } ctrl_state_t;
  typedef struct packed {
    logic       filter;
    logic [3:0] threshold;
  } cfg_t;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int WIN_SIZE_DEF = 5;
  localparam int BORDER = WIN_SIZE_DEF / 2;
endpackage

// File: rtl/denoise_ctrl_sync_edge.sv
// sync_edge: 2-flop synchronizer for async switches plus registered falling-edge detect for pixel-clock syncs
module sync_edge #(
  parameter int SW = 1,
  parameter int EW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [SW-1:0] sw_i,
  output logic [SW-1:0] sw_o,
  input  logic [EW-1:0] ev_i,
  output logic [EW-1:0] fall_o
);
  logic [SW-1:0] meta_q, meta_d, sw_q, sw_d;
  logic [EW-1:0] ev_q, ev_d;
  always_comb begin
    meta_d = sw_i;
    sw_d   = meta_q;
    ev_d   = ev_i;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sw_q   <= '0;
      ev_q   <= '0;
    end else begin
      meta_q <= meta_d;
      sw_q   <= sw_d;
      ev_q   <= ev_d;
    end
  end
  assign sw_o   = sw_q;
  assign fall_o = ev_q & ~ev_i;
endmodule

// File: rtl/denoise_ctrl.sv
// denoise_ctrl: frame-level gating, frame-stable config latch and output-pixel
// coordinate/border tracking for the 5x5 denoise kernel.
module denoise_ctrl
  import denoise_pkg::*;
#(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int WIN_SIZE     = WIN_SIZE_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           vs_ni,
  input  logic           hs_ni,
  input  logic           blank_ni,
  input  logic           vs_ki,
  input  logic           hs_ki,
  input  logic           blank_ki,
  input  logic           filter_sw,
  input  logic [3:0]     threshold_sw,
  output logic           en_o,
  output logic           filter_en_o,
  output logic [3:0]     threshold_o,
  output logic           border_o,
  output logic [X_W-1:0] out_x_o,
  output logic [Y_W-1:0] out_y_o,
  output logic [7:0]     frame_cnt_o,
  output logic           cfg_changed_o
);
  localparam int B = WIN_SIZE / 2;
  localparam logic [X_W-1:0] X_MAX = X_W'(LINE_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_HEIGHT - 1);
  localparam logic [X_W-1:0] X_LO  = X_W'(B);
  localparam logic [X_W-1:0] X_HI  = X_W'(LINE_WIDTH - B);
  localparam logic [Y_W-1:0] Y_LO  = Y_W'(B);
  localparam logic [Y_W-1:0] Y_HI  = Y_W'(FRAME_HEIGHT - B);
  ctrl_state_t    state_q, state_d;
  cfg_t           sw_sync, cfg_q, cfg_d;
  logic           chg_q, chg_d, act_q, act_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           vs_fall, hsk_fall, vsk_fall;
  sync_edge #(.SW(5), .EW(3)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .sw_i   ({filter_sw, threshold_sw}),
    .sw_o   (sw_sync),
    .ev_i   ({vs_ni, hs_ki, vs_ki}),
    .fall_o ({vs_fall, hsk_fall, vsk_fall})
  );
  // act_q remembers whether the kernel line now ending carried any pixel
  always_comb begin
    state_d = (state_q == WAIT_VS)     ? (vs_fall  ? WAIT_ACTIVE : WAIT_VS) :
              (state_q == WAIT_ACTIVE) ? (blank_ni ? RUN : WAIT_ACTIVE) : RUN;
    cfg_d   = vs_fall ? sw_sync : cfg_q;
    chg_d   = vs_fall && (sw_sync != cfg_q);
    cnt_d   = cnt_q + 8'(vs_fall && state_q == RUN);
    act_d   = hsk_fall ? 1'b0 : (act_q | blank_ki);
    x_d     = hsk_fall ? '0 : (blank_ki && x_q != X_MAX) ? x_q + X_W'(1) : x_q;
    y_d     = vsk_fall ? '0 : (hsk_fall && act_q && y_q != Y_MAX) ? y_q + Y_W'(1) : y_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_VS;
      cfg_q   <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  assign en_o          = blank_ni && (state_q != WAIT_VS);
  assign filter_en_o   = cfg_q.filter;
  assign threshold_o   = cfg_q.threshold;
  assign cfg_changed_o = chg_q;
  assign frame_cnt_o   = cnt_q;
  assign out_x_o       = x_q;
  assign out_y_o       = y_q;
  assign border_o      = blank_ki && (x_q < X_LO || x_q >= X_HI || y_q < Y_LO || y_q >= Y_HI);
endmodule

// File: tb/tb_denoise_ctrl.sv
// tb_denoise_ctrl: directed stimulus against a spec-level reference model with a per-cycle compare
module tb_denoise_ctrl;
  import denoise_pkg::*;
  localparam int LW = 16, FH = 8, WS = 5;
  logic clk = 0, reset_n = 0;
  logic vs_ni = 1, hs_ni = 1, blank_ni = 1;
  logic vs_ki = 1, hs_ki = 1, blank_ki = 0;
  logic filter_sw = 1;
  logic [3:0] threshold_sw = 4'd5;
  logic en_o, filter_en_o, border_o, cfg_changed_o;
  logic [3:0] threshold_o;
  logic [9:0] out_x_o;
  logic [8:0] out_y_o;
  logic [7:0] frame_cnt_o;
  int n_cmp = 0, n_bad = 0, n_border = 0, n_pulse = 0;
  int exp_x = 0, exp_y = 0;
  int b0, p0;

  denoise_ctrl #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .WIN_SIZE(WS)) dut (
    .clk(clk), .reset_n(reset_n),
    .vs_ni(vs_ni), .hs_ni(hs_ni), .blank_ni(blank_ni),
    .vs_ki(vs_ki), .hs_ki(hs_ki), .blank_ki(blank_ki),
    .filter_sw(filter_sw), .threshold_sw(threshold_sw),
    .en_o(en_o), .filter_en_o(filter_en_o), .threshold_o(threshold_o),
    .border_o(border_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
    .frame_cnt_o(frame_cnt_o), .cfg_changed_o(cfg_changed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: armed after first vsync, running after first active pixel,
  // config taken from a two-deep switch history at each vsync.
  logic [4:0] s1, s2, m_cfg;
  logic [7:0] m_cnt;
  logic m_armed, m_run, m_chg, vs_prev, m_fall;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 = 0; s2 = 0; m_cfg = 0; m_cnt = 0;
      m_armed = 0; m_run = 0; m_chg = 0; vs_prev = 1;
    end else begin
      m_fall = vs_prev && !vs_ni;
      m_chg = m_fall && (s2 != m_cfg);
      if (m_fall) begin
        if (m_run) m_cnt = m_cnt + 8'd1;
        m_cfg = s2;
      end
      m_run = m_run || (m_armed && blank_ni);
      m_armed = m_armed || m_fall;
      s2 = s1;
      s1 = {filter_sw, threshold_sw};
      vs_prev = vs_ni;
    end
  end

  always @(negedge clk) begin
    chk("en_o", en_o, m_armed & blank_ni);
    chk("cfg", {filter_en_o, threshold_o}, m_cfg);
    chk("cfg_changed_o", cfg_changed_o, m_chg);
    chk("frame_cnt_o", frame_cnt_o, m_cnt);
    if (blank_ki) begin
      chk("out_x_o", out_x_o, exp_x);
      chk("out_y_o", out_y_o, exp_y);
      chk("border_o", border_o, int'(exp_x < BORDER || exp_x >= LW - BORDER ||
                                     exp_y < BORDER || exp_y >= FH - BORDER));
    end else chk("border_o blank", border_o, 0);
    n_border += int'(border_o);
    n_pulse += int'(cfg_changed_o);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic rframe(input int lines, input int px, input bit sw_at_vs = 0, input logic [3:0] thr = 0);
    blank_ni = 0; vs_ni = 0;
    if (sw_at_vs) threshold_sw = thr;
    tick(2);
    vs_ni = 1; tick(2);
    repeat (lines) begin
      blank_ni = 1; tick(px);
      blank_ni = 0; hs_ni = 0; tick(1);
      hs_ni = 1; tick(1);
    end
  endtask

  task automatic kline(input int row, input bit pix);
    hs_ki = 0; tick(2);
    hs_ki = 1; tick(2);
    if (pix) for (int c = 0; c < LW; c++) begin
      exp_x = c; exp_y = row; blank_ki = 1; tick(1);
    end
    blank_ki = 0; tick(1);
  endtask

  task automatic kframe();
    vs_ki = 0; tick(2);
    vs_ki = 1; tick(1);
    kline(0, 0);
    for (int r = 0; r < FH; r++) begin
      kline(r, 1);
      if (r == 0) chk("x peak", out_x_o, LW - 1);
    end
    kline(0, 0);
    chk("y peak", out_y_o, FH - 1);
  endtask

  initial begin
    tick(3);
    chk("rst en", en_o, 0);
    chk("rst thr", threshold_o, 0);
    chk("rst filt", filter_en_o, 0);
    chk("rst cnt", frame_cnt_o, 0);
    chk("rst x", out_x_o, 0);
    reset_n = 1; tick(4);
    chk("en before vs", en_o, 0);
    rframe(2, 4);
    chk("thr A", threshold_o, 5);
    chk("filt A", filter_en_o, 1);
    chk("cnt A", frame_cnt_o, 0);
    blank_ni = 1; threshold_sw = 4'd9; tick(4);
    chk("thr held", threshold_o, 5);
    chk("en run", en_o, 1);
    p0 = n_pulse;
    rframe(2, 4);
    chk("thr B", threshold_o, 9);
    chk("cnt B", frame_cnt_o, 1);
    chk("pulse B", n_pulse - p0, 1);
    p0 = n_pulse;
    rframe(2, 4, 1, 4'd3);
    chk("thr C", threshold_o, 9);
    chk("pulse C", n_pulse - p0, 0);
    p0 = n_pulse;
    rframe(2, 4);
    chk("thr D", threshold_o, 3);
    chk("pulse D", n_pulse - p0, 1);
    chk("cnt D", frame_cnt_o, 3);
    for (int f = 0; f < 2; f++) begin
      b0 = n_border;
      kframe();
      chk("border count", n_border - b0, 80);
    end
    blank_ki = 1;
    for (int c = 0; c < 3; c++) begin exp_x = c; exp_y = FH - 1; tick(1); end
    blank_ki = 0; hs_ki = 0; vs_ki = 0; tick(1);
    hs_ki = 1; vs_ki = 1; tick(1);
    chk("x clr", out_x_o, 0);
    chk("y clr", out_y_o, 0);
    p0 = n_pulse;
    repeat (253) rframe(1, 2);
    chk("cnt wrap", frame_cnt_o, 0);
    chk("no pulses", n_pulse - p0, 0);
    blank_ni = 1; tick(2);
    chk("en pre rst", en_o, 1);
    #1 reset_n = 0;
    #1;
    chk("arst en", en_o, 0);
    chk("arst cnt", frame_cnt_o, 0);
    chk("arst thr", threshold_o, 0);
    chk("arst filt", filter_en_o, 0);
    chk("arst chg", cfg_changed_o, 0);
    chk("arst y", out_y_o, 0);
    tick(2);
    reset_n = 1; tick(3);
    chk("en after rst", en_o, 0);
    rframe(1, 3);
    blank_ni = 1; tick(1);
    chk("en rearm", en_o, 1);
    chk("thr rearm", threshold_o, 3);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
